// File: rtl/hazard_detection_unit.sv
// ============================================================================
// Module      : hazard_detection_unit
// Description : Load-use stall, branch flush and operand forwarding control
//               for a 5-stage RV32I pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detection_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_ID,
    input  logic             Branch_ID,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_OP_NONE  = 2'd0;
    localparam logic [1:0] c_OP_ALU   = 2'd1;
    localparam logic [1:0] c_OP_LOAD  = 2'd2;
    localparam logic [1:0] c_OP_STORE = 2'd3;

    localparam logic [1:0] c_FWD_RF   = 2'd0;
    localparam logic [1:0] c_FWD_EX   = 2'd1;
    localparam logic [1:0] c_FWD_MEM  = 2'd2;
    localparam logic [1:0] c_FWD_LOAD = 2'd3;

    logic [1:0]       r_optype_ex_q,  w_optype_ex_d;
    logic [4:0]       r_rd_ex_q,      w_rd_ex_d;
    logic [4:0]       r_rs2_ex_q,     w_rs2_ex_d;
    logic [1:0]       r_optype_mem_q, w_optype_mem_d;
    logic [4:0]       r_rd_mem_q,     w_rd_mem_d;
    logic [CNT_W-1:0] r_stall_cnt_q,  w_stall_cnt_d;

    logic w_stall;
    logic w_rs1_hit_ex_load;
    logic w_rs2_hit_ex_load;

    // An EX-slot load deliberately yields 0 here even when MEM also matches:
    // the load-use stall covers that case and the next cycle selects load data.
    function automatic logic [1:0] fwd_sel(
        input logic       use_rs,
        input logic [4:0] rs,
        input logic [1:0] op_ex,
        input logic [4:0] rd_ex,
        input logic [1:0] op_mem,
        input logic [4:0] rd_mem
    );
        logic [1:0] sel;
        logic       hit_ex;
        logic       hit_mem;
        sel     = c_FWD_RF;
        hit_ex  = use_rs && (rs != 5'd0) && (rs == rd_ex);
        hit_mem = use_rs && (rs != 5'd0) && (rs == rd_mem);
        if (hit_ex && (op_ex == c_OP_ALU)) begin
            sel = c_FWD_EX;
        end else if (hit_ex && (op_ex == c_OP_LOAD)) begin
            sel = c_FWD_RF;
        end else if (hit_mem && (op_mem == c_OP_ALU)) begin
            sel = c_FWD_MEM;
        end else if (hit_mem && (op_mem == c_OP_LOAD)) begin
            sel = c_FWD_LOAD;
        end
        return sel;
    endfunction

    always_comb begin
        w_rs1_hit_ex_load = rs1use_ID && (rs1_ID == r_rd_ex_q);
        w_rs2_hit_ex_load = rs2use_ID && (rs2_ID == r_rd_ex_q)
                            && (hazard_optype_ID != c_OP_STORE);
        w_stall = (r_optype_ex_q == c_OP_LOAD) && (r_rd_ex_q != 5'd0)
                  && (w_rs1_hit_ex_load || w_rs2_hit_ex_load);

        PC_EN_IF     = !w_stall;
        reg_FD_EN    = !w_stall;
        reg_DE_flush = w_stall;
        // Branch operands are stale during a stall, so the flush waits a cycle.
        reg_FD_flush = Branch_ID && !w_stall;

        forward_ctrl_A = fwd_sel(rs1use_ID, rs1_ID, r_optype_ex_q, r_rd_ex_q,
                                 r_optype_mem_q, r_rd_mem_q);
        forward_ctrl_B = fwd_sel(rs2use_ID, rs2_ID, r_optype_ex_q, r_rd_ex_q,
                                 r_optype_mem_q, r_rd_mem_q);
        forward_ctrl_ls = (r_optype_ex_q == c_OP_STORE) && (r_optype_mem_q == c_OP_LOAD)
                          && (r_rd_mem_q != 5'd0) && (r_rs2_ex_q == r_rd_mem_q);
        stall_cnt = r_stall_cnt_q;
    end

    always_comb begin
        w_optype_mem_d = r_optype_ex_q;
        w_rd_mem_d     = r_rd_ex_q;
        w_optype_ex_d  = hazard_optype_ID;
        w_rd_ex_d      = rd_ID;
        w_rs2_ex_d     = rs2_ID;
        w_stall_cnt_d  = r_stall_cnt_q;
        if (w_stall) begin
            w_optype_ex_d = c_OP_NONE;
            w_rd_ex_d     = 5'd0;
            w_rs2_ex_d    = 5'd0;
            if (r_stall_cnt_q != {CNT_W{1'b1}}) begin
                w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_optype_ex_q  <= c_OP_NONE;
            r_rd_ex_q      <= 5'd0;
            r_rs2_ex_q     <= 5'd0;
            r_optype_mem_q <= c_OP_NONE;
            r_rd_mem_q     <= 5'd0;
            r_stall_cnt_q  <= '0;
        end else begin
            r_optype_ex_q  <= w_optype_ex_d;
            r_rd_ex_q      <= w_rd_ex_d;
            r_rs2_ex_q     <= w_rs2_ex_d;
            r_optype_mem_q <= w_optype_mem_d;
            r_rd_mem_q     <= w_rd_mem_d;
            r_stall_cnt_q  <= w_stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Vector-table bench for hazard_detection_unit, with a narrow
//               counter instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hazard_optype_ID;
    logic        rs1use_ID, rs2use_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic        Branch_ID;

    logic        PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
    logic [1:0]  forward_ctrl_A, forward_ctrl_B;
    logic        forward_ctrl_ls;
    logic [31:0] stall_cnt;

    logic        s_pc_en, s_fd_en, s_fd_flush, s_de_flush;
    logic [1:0]  s_fa, s_fb;
    logic        s_fls;
    logic [3:0]  s_stall_cnt;

    hazard_detection_unit #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .hazard_optype_ID(hazard_optype_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .Branch_ID(Branch_ID),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
        .reg_DE_flush(reg_DE_flush), .forward_ctrl_A(forward_ctrl_A),
        .forward_ctrl_B(forward_ctrl_B), .forward_ctrl_ls(forward_ctrl_ls),
        .stall_cnt(stall_cnt)
    );

    hazard_detection_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .hazard_optype_ID(hazard_optype_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .Branch_ID(Branch_ID),
        .PC_EN_IF(s_pc_en), .reg_FD_EN(s_fd_en), .reg_FD_flush(s_fd_flush),
        .reg_DE_flush(s_de_flush), .forward_ctrl_A(s_fa),
        .forward_ctrl_B(s_fb), .forward_ctrl_ls(s_fls),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    // ctl = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, fwdA, fwdB, fwd_ls}
    typedef struct packed {
        logic [1:0]  op;
        logic        u1;
        logic        u2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        br;
        logic [8:0]  ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[29];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mkv(input logic [1:0] op, input logic u1, input logic u2,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic br,
                                 input logic stall, input logic ffl,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic fls, input int cnt);
        vec_t v;
        v.op  = op;  v.u1  = u1;  v.u2 = u2;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.br = br;
        v.ctl = {~stall, ~stall, ffl, stall, fa, fb, fls};
        v.cnt = cnt;
        return v;
    endfunction

    task automatic check_out(input string name);
        vec_t        e;
        logic [8:0]  got;
        logic [8:0]  got_s;
        logic [3:0]  exp_s;
        if (sb_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e     = sb_q.pop_front();
        got   = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
                 forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
        got_s = {s_pc_en, s_fd_en, s_fd_flush, s_de_flush, s_fa, s_fb, s_fls};
        exp_s = (e.cnt > 32'd15) ? 4'd15 : e.cnt[3:0];
        n_vec++;
        if (got !== e.ctl) begin
            n_miss++;
            $display("FAIL %s ctl: got %b expected %b", name, got, e.ctl);
        end
        n_vec++;
        if (stall_cnt !== e.cnt) begin
            n_miss++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, e.cnt);
        end
        n_vec++;
        if ((s_stall_cnt !== exp_s) || (got_s !== e.ctl)) begin
            n_miss++;
            $display("FAIL %s narrow: got cnt %0d ctl %b expected cnt %0d ctl %b",
                     name, s_stall_cnt, got_s, exp_s, e.ctl);
        end
    endtask

    task automatic drive(input vec_t v);
        hazard_optype_ID = v.op;
        rs1use_ID = v.u1;  rs2use_ID = v.u2;
        rs1_ID = v.rs1;    rs2_ID = v.rs2;  rd_ID = v.rd;
        Branch_ID = v.br;
        sb_q.push_back(v);
    endtask

    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_out(name);
    endtask

    initial begin
        //            op u1 u2 rs1 rs2 rd br  st ffl fa fb ls cnt
        vecs[0]  = mkv(1, 1, 0,  0,  1, 5, 0,  0, 0, 0, 0, 0, 0); // addi x5,x0,1
        vecs[1]  = mkv(1, 1, 1,  5,  5, 6, 0,  0, 0, 1, 1, 0, 0); // add x6,x5,x5
        vecs[2]  = mkv(1, 1, 0,  0,  0, 5, 0,  0, 0, 0, 0, 0, 0); // addi x5
        vecs[3]  = mkv(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0); // nop
        vecs[4]  = mkv(1, 1, 1,  5,  0, 7, 0,  0, 0, 2, 0, 0, 0); // sub x7,x5,x0
        vecs[5]  = mkv(2, 1, 0,  0,  0, 5, 0,  0, 0, 0, 0, 0, 0); // lw x5
        vecs[6]  = mkv(1, 1, 1,  5,  0, 6, 0,  1, 0, 0, 0, 0, 0); // add: load-use stall
        vecs[7]  = mkv(1, 1, 1,  5,  0, 6, 0,  0, 0, 3, 0, 0, 1); // add retried
        vecs[8]  = mkv(2, 1, 0,  0,  0, 5, 0,  0, 0, 0, 0, 0, 1); // lw x5
        vecs[9]  = mkv(3, 1, 1,  0,  5, 4, 0,  0, 0, 0, 0, 0, 1); // sw x5: no stall
        vecs[10] = mkv(0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 1); // sw in EX, lw in MEM
        vecs[11] = mkv(1, 1, 1,  4,  4, 6, 0,  0, 0, 0, 0, 0, 1); // store rd never forwards
        vecs[12] = mkv(1, 1, 0,  0,  1, 0, 0,  0, 0, 0, 0, 0, 1); // addi x0
        vecs[13] = mkv(1, 1, 1,  0,  0, 6, 0,  0, 0, 0, 0, 0, 1); // add x6,x0,x0
        vecs[14] = mkv(2, 1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1); // lw x0
        vecs[15] = mkv(1, 1, 1,  0,  6, 7, 0,  0, 0, 0, 2, 0, 1); // no stall on x0 load
        vecs[16] = mkv(2, 1, 0,  0,  0, 5, 1,  0, 1, 0, 0, 0, 1); // branch flush, no stall
        vecs[17] = mkv(0, 1, 1,  5,  7, 0, 1,  1, 0, 0, 2, 0, 1); // stall beats branch
        vecs[18] = mkv(0, 1, 1,  5,  7, 0, 1,  0, 1, 3, 0, 0, 2); // branch re-evaluated
        vecs[19] = mkv(2, 1, 0,  0,  0, 9, 0,  0, 0, 0, 0, 0, 2); // lw x9
        vecs[20] = mkv(1, 1, 1,  1,  9,10, 0,  1, 0, 0, 0, 0, 2); // rs2 load-use stall
        vecs[21] = mkv(1, 1, 0,  1,  9,10, 0,  0, 0, 0, 0, 0, 3); // rs2 unused
        vecs[22] = mkv(1, 1, 0,  0,  0, 5, 0,  0, 0, 0, 0, 0, 3); // addi x5
        vecs[23] = mkv(2, 1, 0,  5,  0, 5, 0,  0, 0, 1, 0, 0, 3); // lw x5,0(x5)
        vecs[24] = mkv(1, 1, 1,  5,  0, 6, 0,  1, 0, 0, 0, 0, 3); // EX load masks MEM ALU
        vecs[25] = mkv(1, 1, 1,  5,  0, 6, 0,  0, 0, 3, 0, 0, 4);
        vecs[26] = mkv(1, 1, 0,  0,  0, 8, 0,  0, 0, 0, 0, 0, 4); // addi x8
        vecs[27] = mkv(1, 1, 0,  8,  0, 8, 0,  0, 0, 1, 0, 0, 4); // addi x8,x8
        vecs[28] = mkv(1, 1, 1,  8,  8, 9, 0,  0, 0, 1, 1, 0, 4); // EX beats MEM

        rst = 1'b1;
        hazard_optype_ID = '0; rs1use_ID = 1'b0; rs2use_ID = 1'b0;
        rs1_ID = '0; rs2_ID = '0; rd_ID = '0; Branch_ID = 1'b0;
        step("reset_state", mkv(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset pulse while a load-use stall is active.
        step("pre_rst_addi", mkv(1, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 4));
        step("pre_rst_lw",   mkv(2, 1, 0, 5, 0, 7, 0, 0, 0, 1, 0, 0, 4));
        step("pre_rst_use",  mkv(1, 1, 1, 7, 5, 8, 0, 1, 0, 0, 2, 0, 4));
        #1 rst = 1'b1;
        sb_q.push_back(mkv(1, 1, 1, 7, 5, 8, 0, 0, 0, 0, 0, 0, 0));
        #0.5 check_out("rst_async");
        #0.5 rst = 1'b0;

        // Counter saturation: a load-use pair every two cycles.
        for (int k = 0; k < 20; k++) begin
            step($sformatf("sat_ld%0d", k),  mkv(2, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, k));
            step($sformatf("sat_use%0d", k), mkv(1, 1, 1, 5, 0, 6, 0, 1, 0, 0, 0, 0, k));
        end
        step("sat_end", mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes per-instruction hazard info from the ID-stage decoder: hazard_optype, rs1use/rs2use, register indices and the resolved branch.
- Tracks in-flight destination registers for EX and MEM internally.
- Drives PC/pipeline-register enables, stalls and flushes, forwarding selects, and a saturating stall counter.

Parameters:
- CNT_W, 32, width of the stall_cnt performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- hazard_optype_ID  in  2  decoded class of the ID instruction: 0 none, 1 ALU-result writer (R/I/LUI/AUIPC/JAL/JALR), 2 load, 3 store
- rs1use_ID  in  1  ID instruction reads rs1
- rs2use_ID  in  1  ID instruction reads rs2
- rs1_ID  in  5  rs1 index of the ID instruction
- rs2_ID  in  5  rs2 index of the ID instruction
- rd_ID  in  5  rd index of the ID instruction
- Branch_ID  in  1  taken branch/jump resolved in ID
- PC_EN_IF  out  1  PC register enable
- reg_FD_EN  out  1  IF/ID register enable
- reg_FD_flush  out  1  IF/ID flush, inserts NOP
- reg_DE_flush  out  1  ID/EX flush, inserts bubble
- forward_ctrl_A  out  2  rs1 operand select: 0 regfile, 1 EX ALU out, 2 MEM ALU out, 3 MEM load data
- forward_ctrl_B  out  2  rs2 operand select, same encoding as forward_ctrl_A
- forward_ctrl_ls  out  1  store data in EX/MEM taken from MEM load data
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating

Behaviour:
- State:
  - EX slot: optype_EX, rd_EX, rs2_EX.
  - MEM slot: optype_MEM, rd_MEM.
  - stall_cnt.
- Reset clears all state to 0; optype 0 means no hazard source.
- Outputs are combinational from state and ID inputs. Immediately after reset: forward_ctrl_A = forward_ctrl_B = 0, forward_ctrl_ls = 0, no stall, stall_cnt = 0.
- Register-match rule: a slot "matches" rsX only if rdX == rsX and rsX != 0. x0 never forwards or stalls.
- Load-use stall (stall = 1) when optype_EX == 2, rd_EX != 0, and either:
  - rs1use_ID & rs1_ID == rd_EX, or
  - rs2use_ID & rs2_ID == rd_EX & hazard_optype_ID != 3.
  - Store data from a load is forwarded later via forward_ctrl_ls, so a store's rs2 does not stall.
- On stall: PC_EN_IF = 0, reg_FD_EN = 0, reg_DE_flush = 1, reg_FD_flush = 0. Latency is exactly 1 stall cycle per load-use pair.
- No stall: PC_EN_IF = 1, reg_FD_EN = 1, reg_DE_flush = 0, reg_FD_flush = Branch_ID.
- Stall and Branch_ID in the same cycle: stall wins and flush is suppressed, because the branch operands are invalid. Branch_ID is re-evaluated the next cycle.
- forward_ctrl_A, evaluated for rs1 when rs1use_ID = 1 (otherwise 0), highest priority first:
  - EX match with optype_EX == 1 → 1
  - MEM match with optype_MEM == 1 → 2
  - MEM match with optype_MEM == 2 → 3
  - otherwise 0
  - An EX-slot load masks an older MEM match; the stall covers that case.
- forward_ctrl_B uses the same rules with rs2_ID / rs2use_ID.
- The register file is write-before-read, so no WB forwarding is produced.
- forward_ctrl_ls = 1 when optype_EX == 3, optype_MEM == 2, and rs2_EX matches rd_MEM with rd_MEM != 0.
- Slot advance each clock edge:
  - MEM slot <= EX slot.
  - EX slot <= {hazard_optype_ID, rd_ID, rs2_ID}, or all zeros when stall = 1 (bubble).
  - Store/none instructions are tracked with their optype, but only optype 1/2 can match as forwarding sources.
- Branch flush does not clear the EX slot: the flushed instruction is the one in IF, and the ID instruction proceeds.
- stall_cnt increments by 1 on each stall cycle and holds at all-ones; it does not wrap.
- Reset asserted mid-operation clears both slots and the counter asynchronously. Forwarding and stall outputs drop to 0 immediately, without waiting for a clock edge.

Test Plan:
- addi x5,x0,1 then add x6,x5,x5 back-to-back → in the add's ID cycle, forward_ctrl_A = forward_ctrl_B = 1; no stall.
- addi x5; nop; sub x7,x5,x0 → forward_ctrl_A = 2, forward_ctrl_B = 0.
- lw x5,0(x0) then add x6,x5,x0:
  - cycle 1: PC_EN_IF = 0, reg_FD_EN = 0, reg_DE_flush = 1, stall_cnt 0 → 1.
  - next cycle: forward_ctrl_A = 3, no stall.
- lw x5 then sw x5,4(x0) → no stall; with the sw in EX and the lw in MEM, forward_ctrl_ls = 1.
- Writes to x0 (addi x0,x0,1 then add x6,x0,x0) → all forward selects 0, no stall. Load-use hazard with Branch_ID = 1 in the same cycle → reg_FD_flush = 0, stall asserted.
- Assert rst for 1 ns between clock edges while a load sits in the EX slot → stall and forward outputs go to 0 immediately, stall_cnt = 0. Force stall_cnt to all-ones with CNT_W = 4 → stays at 15 on further stalls.
